// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command receiver: command codes,
// FSM states, the queued sprite record layout and status-byte bit positions.
package spi_cmd_pkg;

  typedef enum logic [7:0] {
    CMD_DRAW   = 8'h01,
    CMD_LOAD   = 8'h02,
    CMD_STATUS = 8'h03,
    CMD_CLEAR  = 8'h04
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DRAW,
    ST_LOAD_SEL,
    ST_LOAD_DATA,
    ST_STATUS,
    ST_DISCARD
  } state_e;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } sprite_record_t;

  localparam int unsigned RECORD_BYTES = 6;

  localparam int unsigned STAT_OVERFLOW  = 7;
  localparam int unsigned STAT_CMD_ERROR = 6;
  localparam int unsigned STAT_FULL      = 5;
  localparam int unsigned STAT_EMPTY     = 4;
  localparam int unsigned STAT_OCC_LSB   = 0;
  localparam int unsigned STAT_OCC_W     = 4;

endpackage

// File: rtl/sprite_fifo.sv
// First-word-fall-through queue of arbitrary element type with occupancy count.
// A push on a full queue succeeds only when a pop happens in the same cycle.
module sprite_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter type         T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  T mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Storage is not reset, so the head is forced to zero while nothing is queued.
  assign dout  = (count_q == '0) ? '0 : mem[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

endmodule

// File: rtl/spi_command_receiver.sv
// Single-clock SPI slave command engine: oversampled pins, byte deserialiser,
// command FSM routing bytes to the sprite draw queue or sprite storage writes.
module spi_command_receiver
  import spi_cmd_pkg::*;
#(
  parameter int unsigned SPRITE_NUM    = 16,
  parameter int unsigned SPRITE_ADDR_W = 12,
  parameter int unsigned QUEUE_DEPTH   = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                          sys_clock,
  input  logic                          reset_n,
  input  logic                          spi_sck,
  input  logic                          spi_cs,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic [$clog2(SPRITE_NUM)-1:0] sprite_select,
  output logic                          sprite_w_en,
  output logic [SPRITE_ADDR_W-1:0]      sprite_w_addr,
  output logic [7:0]                    sprite_w_data,
  input  logic                          dequeue,
  output logic                          is_empty,
  output logic                          is_full,
  output logic [7:0]                    sprite_id,
  output logic [15:0]                   sprite_x,
  output logic [15:0]                   sprite_y,
  output logic [7:0]                    sprite_scale,
  output logic                          overflow,
  output logic                          cmd_error
);

  localparam int unsigned SEL_W     = $clog2(SPRITE_NUM);
  localparam int unsigned CNT_W     = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [2:0]  LAST_BYTE = 3'(RECORD_BYTES - 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall;

  state_e               state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           rec_byte_q, rec_byte_d;
  logic [39:0]          rec_q, rec_d;
  logic                 push_q, push_d;
  sprite_record_t       push_data_q, push_data_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SPRITE_ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic                 w_en_q, w_en_d;
  logic [SPRITE_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]           w_data_q, w_data_d;
  logic [7:0]           status_sr_q, status_sr_d;
  logic                 overflow_q, overflow_d;
  logic                 cmd_error_q, cmd_error_d;

  logic                 byte_done, clear_flags, set_err, drop;
  logic [7:0]           byte_val, status_word;
  logic [31:0]          occ32;
  logic [STAT_OCC_W-1:0] occ_sat;

  sprite_record_t       head;
  logic                 fifo_empty, fifo_full;
  logic [CNT_W-1:0]     fifo_count;

  sprite_fifo #(
    .DEPTH(QUEUE_DEPTH),
    .T    (sprite_record_t)
  ) u_fifo (
    .clk  (sys_clock),
    .rst_n(reset_n),
    .push (push_q),
    .din  (push_data_q),
    .pop  (dequeue),
    .dout (head),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sck_rise    = sck_s && !sck_prev_q;
    sck_fall    = !sck_s && sck_prev_q;
    cs_fall     = !cs_s && cs_prev_q;
  end

  always_comb begin
    occ32   = 32'(fifo_count);
    occ_sat = (occ32 > 32'd15) ? '1 : occ32[STAT_OCC_W-1:0];
    status_word = '0;
    status_word[STAT_OVERFLOW]  = overflow_q;
    status_word[STAT_CMD_ERROR] = cmd_error_q;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_EMPTY]     = fifo_empty;
    status_word[STAT_OCC_LSB +: STAT_OCC_W] = occ_sat;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rec_byte_d  = rec_byte_q;
    rec_d       = rec_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    sel_d       = sel_q;
    addr_cnt_d  = addr_cnt_q;
    w_en_d      = 1'b0;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    status_sr_d = status_sr_q;
    clear_flags = 1'b0;
    set_err     = 1'b0;
    byte_done   = 1'b0;
    byte_val    = {shift_q[6:0], mosi_s};

    if (cs_s) begin
      // Deselect aborts everything: partial byte and partial record are dropped.
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      rec_byte_d  = '0;
      status_sr_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        state_d = ST_CMD;
      end
    end else begin
      if (sck_rise) begin
        shift_d   = byte_val;
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_done = (bit_cnt_q == 3'd7);
      end
      // Status bit 7 is preloaded at command completion, so the falling edge
      // that closes the command byte must not shift.
      if (sck_fall && (((state_q == ST_STATUS) && (bit_cnt_q != '0)) ||
                       (state_q == ST_DISCARD))) begin
        status_sr_d = {status_sr_q[6:0], 1'b0};
      end
      if (byte_done) begin
        case (state_q)
          ST_CMD: begin
            case (byte_val)
              CMD_DRAW: begin
                state_d    = ST_DRAW;
                rec_byte_d = '0;
              end
              CMD_LOAD:   state_d = ST_LOAD_SEL;
              CMD_STATUS: begin
                state_d     = ST_STATUS;
                status_sr_d = status_word;
              end
              CMD_CLEAR: begin
                state_d     = ST_DISCARD;
                clear_flags = 1'b1;
              end
              default: begin
                state_d = ST_DISCARD;
                set_err = 1'b1;
              end
            endcase
          end
          ST_DRAW: begin
            rec_d = {rec_q[31:0], byte_val};
            if (rec_byte_q == LAST_BYTE) begin
              push_d      = 1'b1;
              push_data_d = {rec_q, byte_val};
              rec_byte_d  = '0;
            end else begin
              rec_byte_d = rec_byte_q + 3'd1;
            end
          end
          ST_LOAD_SEL: begin
            sel_d      = byte_val[SEL_W-1:0];
            addr_cnt_d = '0;
            state_d    = ST_LOAD_DATA;
          end
          ST_LOAD_DATA: begin
            w_en_d     = 1'b1;
            w_addr_d   = addr_cnt_q;
            w_data_d   = byte_val;
            addr_cnt_d = addr_cnt_q + SPRITE_ADDR_W'(1);
          end
          ST_STATUS: state_d = ST_DISCARD;
          default: ;
        endcase
      end
    end

    drop        = push_q && fifo_full && !dequeue;
    overflow_d  = (overflow_q && !clear_flags) || drop;
    cmd_error_d = (cmd_error_q && !clear_flags) || set_err;
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rec_byte_q  <= '0;
      rec_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      sel_q       <= '0;
      addr_cnt_q  <= '0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      status_sr_q <= '0;
      overflow_q  <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rec_byte_q  <= rec_byte_d;
      rec_q       <= rec_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      sel_q       <= sel_d;
      addr_cnt_q  <= addr_cnt_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      status_sr_q <= status_sr_d;
      overflow_q  <= overflow_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign spi_miso      = status_sr_q[7];
  assign sprite_select = sel_q;
  assign sprite_w_en   = w_en_q;
  assign sprite_w_addr = w_addr_q;
  assign sprite_w_data = w_data_q;
  assign is_empty      = fifo_empty;
  assign is_full       = fifo_full;
  assign sprite_id     = head.id;
  assign sprite_x      = head.x;
  assign sprite_y      = head.y;
  assign sprite_scale  = head.scale;
  assign overflow      = overflow_q;
  assign cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_spi_command_receiver.sv
// Directed bench for spi_command_receiver: DRAW, LOAD with address wrap,
// full-queue overflow, STATUS/CLEAR readback, abort, unknown command and reset.
module tb_spi_command_receiver;

  localparam int unsigned TB_ADDR_W = 4;

  logic                 sys_clock = 1'b0;
  logic                 reset_n;
  logic                 spi_sck, spi_cs, spi_mosi, spi_miso;
  logic [3:0]           sprite_select;
  logic                 sprite_w_en;
  logic [TB_ADDR_W-1:0] sprite_w_addr;
  logic [7:0]           sprite_w_data;
  logic                 dequeue;
  logic                 is_empty, is_full;
  logic [7:0]           sprite_id, sprite_scale;
  logic [15:0]          sprite_x, sprite_y;
  logic                 overflow, cmd_error;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned          wen_cnt = 0;
  logic [TB_ADDR_W-1:0] cap_addr [$];
  logic [7:0]           cap_data [$];

  spi_command_receiver #(
    .SPRITE_ADDR_W(TB_ADDR_W)
  ) dut (
    .sys_clock    (sys_clock),
    .reset_n      (reset_n),
    .spi_sck      (spi_sck),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .sprite_select(sprite_select),
    .sprite_w_en  (sprite_w_en),
    .sprite_w_addr(sprite_w_addr),
    .sprite_w_data(sprite_w_data),
    .dequeue      (dequeue),
    .is_empty     (is_empty),
    .is_full      (is_full),
    .sprite_id    (sprite_id),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_scale (sprite_scale),
    .overflow     (overflow),
    .cmd_error    (cmd_error)
  );

  always #5 sys_clock = ~sys_clock;

  always @(negedge sys_clock) begin
    if (sprite_w_en) begin
      wen_cnt++;
      cap_addr.push_back(sprite_w_addr);
      cap_data.push_back(sprite_w_data);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge sys_clock);
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode 0, MSB first, 8 sys clocks per sck period; MISO sampled at each rising edge.
  task automatic spi_byte(input logic [7:0] b, input logic deq_last, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_sck  = 1'b0;
      spi_mosi = b[i];
      tick(4);
      rx[i]   = spi_miso;
      spi_sck = 1'b1;
      if (i == 0 && deq_last) begin
        tick(3);
        dequeue = 1'b1;
        tick(1);
        dequeue = 1'b0;
      end else begin
        tick(4);
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx;
    spi_byte(b, 1'b0, rx);
  endtask

  task automatic send_rec(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                          input logic [7:0] scale, input logic deq_last);
    logic [7:0] rx;
    send(id); send(x[15:8]); send(x[7:0]); send(y[15:8]); send(y[7:0]);
    spi_byte(scale, deq_last, rx);
  endtask

  task automatic cs_start();
    spi_cs = 1'b0;
    tick(8);
  endtask

  task automatic cs_end();
    spi_sck = 1'b0;
    tick(4);
    spi_cs = 1'b1;
    tick(12);
  endtask

  task automatic pop_one();
    dequeue = 1'b1;
    tick(1);
    dequeue = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [7:0] rx;
    int unsigned wen_base;

    reset_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; dequeue = 1'b0;
    tick(3);
    check("rst_empty", 48'(is_empty), 48'd1);
    check("rst_full", 48'(is_full), 48'd0);
    check("rst_ovf", 48'(overflow), 48'd0);
    check("rst_err", 48'(cmd_error), 48'd0);
    check("rst_miso", 48'(spi_miso), 48'd0);
    check("rst_wen", 48'(sprite_w_en), 48'd0);
    check("rst_id", 48'(sprite_id), 48'd0);
    reset_n = 1'b1;
    tick(4);

    // DRAW single record
    cs_start(); send(8'h01); send_rec(8'h05, 16'h012C, 16'h00C8, 8'h02, 1'b0); cs_end();
    check("draw_empty", 48'(is_empty), 48'd0);
    check("draw_id", 48'(sprite_id), 48'd5);
    check("draw_x", 48'(sprite_x), 48'd300);
    check("draw_y", 48'(sprite_y), 48'd200);
    check("draw_scale", 48'(sprite_scale), 48'd2);
    pop_one();
    check("draw_pop_empty", 48'(is_empty), 48'd1);

    // LOAD three bytes
    cs_start(); send(8'h02); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); cs_end();
    check("load_sel", 48'(sprite_select), 48'd3);
    check("load_wen_cnt", 48'(wen_cnt), 48'd3);
    for (int i = 0; i < 3; i++) begin
      check("load_addr", 48'(cap_addr[i]), 48'(i));
    end
    check("load_data0", 48'(cap_data[0]), 48'hAA);
    check("load_data1", 48'(cap_data[1]), 48'hBB);
    check("load_data2", 48'(cap_data[2]), 48'hCC);

    // LOAD 2^ADDR_W+1 bytes: address wraps back to 0
    cs_start(); send(8'h02); send(8'h01);
    for (int i = 0; i < 17; i++) send(8'(8'h40 + i));
    cs_end();
    check("wrap_sel", 48'(sprite_select), 48'd1);
    check("wrap_wen_cnt", 48'(wen_cnt), 48'd20);
    check("wrap_addr_first", 48'(cap_addr[3]), 48'd0);
    check("wrap_addr_last16", 48'(cap_addr[18]), 48'd15);
    check("wrap_addr_wrap", 48'(cap_addr[19]), 48'd0);
    check("wrap_data_wrap", 48'(cap_data[19]), 48'h50);

    // Fill the queue, then one more record with dequeue in the push cycle
    cs_start(); send(8'h01);
    for (int r = 0; r < 16; r++) send_rec(8'(r), 16'(16'h0100 + r), 16'(16'h0200 + r), 8'(r), 1'b0);
    check("fill_full", 48'(is_full), 48'd1);
    send_rec(8'hA0, 16'h0A0A, 16'h0B0B, 8'h0C, 1'b1);
    cs_end();
    check("deq_ovf", 48'(overflow), 48'd0);
    check("deq_full", 48'(is_full), 48'd1);
    check("deq_head_id", 48'(sprite_id), 48'd1);
    check("deq_head_x", 48'(sprite_x), 48'h0101);

    // Extra record on a full queue is dropped
    cs_start(); send(8'h01); send_rec(8'hB0, 16'h1111, 16'h2222, 8'h33, 1'b0); cs_end();
    check("ovf_set", 48'(overflow), 48'd1);
    check("ovf_head_id", 48'(sprite_id), 48'd1);
    check("ovf_full", 48'(is_full), 48'd1);

    // STATUS readback, then CLEAR and STATUS again
    cs_start(); send(8'h03); spi_byte(8'h00, 1'b0, rx);
    check("status_ovf", 48'(rx), 48'hAF);
    spi_byte(8'h00, 1'b0, rx);
    check("status_tail", 48'(rx), 48'h00);
    cs_end();
    cs_start(); send(8'h04); cs_end();
    check("clear_ovf", 48'(overflow), 48'd0);
    cs_start(); send(8'h03); spi_byte(8'h00, 1'b0, rx); cs_end();
    check("status_clr", 48'(rx), 48'h2F);

    // Drain; final pop on an empty queue is ignored
    for (int i = 0; i < 15; i++) pop_one();
    check("drain_head_id", 48'(sprite_id), 48'hA0);
    pop_one();
    check("drain_empty", 48'(is_empty), 48'd1);
    pop_one();
    cs_start(); send(8'h03); spi_byte(8'h00, 1'b0, rx); cs_end();
    check("status_empty", 48'(rx), 48'h10);

    // Abort after 3 record bytes, then a clean record
    cs_start(); send(8'h01); send(8'h11); send(8'h22); send(8'h33); cs_end();
    check("abort_empty", 48'(is_empty), 48'd1);
    cs_start(); send(8'h01); send_rec(8'h11, 16'h0010, 16'h0020, 8'h03, 1'b0); cs_end();
    check("post_abort_empty", 48'(is_empty), 48'd0);
    check("post_abort_id", 48'(sprite_id), 48'h11);
    check("post_abort_x", 48'(sprite_x), 48'h0010);
    check("post_abort_y", 48'(sprite_y), 48'h0020);
    check("post_abort_scale", 48'(sprite_scale), 48'd3);

    // Unknown command: error flag, no storage writes, no enqueue
    wen_base = wen_cnt;
    cs_start(); send(8'h7E); send(8'h02); send(8'h03);
    send_rec(8'h01, 16'h0203, 16'h0405, 8'h06, 1'b0); cs_end();
    check("unk_err", 48'(cmd_error), 48'd1);
    check("unk_no_write", 48'(wen_cnt), 48'(wen_base));
    check("unk_head_id", 48'(sprite_id), 48'h11);
    cs_start(); send(8'h03); spi_byte(8'h00, 1'b0, rx); cs_end();
    check("unk_status", 48'(rx), 48'h41);

    // Reset in the middle of a DRAW transaction
    cs_start(); send(8'h01); send(8'h05); send(8'h06);
    reset_n = 1'b0;
    #1;
    check("mid_rst_empty", 48'(is_empty), 48'd1);
    check("mid_rst_err", 48'(cmd_error), 48'd0);
    check("mid_rst_ovf", 48'(overflow), 48'd0);
    check("mid_rst_sel", 48'(sprite_select), 48'd0);
    check("mid_rst_wdata", 48'(sprite_w_data), 48'd0);
    check("mid_rst_id", 48'(sprite_id), 48'd0);
    check("mid_rst_miso", 48'(spi_miso), 48'd0);
    spi_cs = 1'b1; spi_sck = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
